// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register file's single write port between
// the ALU writeback (source A) and the load writeback (source B).
module regfile_wb_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              hold,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic [ADDR_W-1:0] a_reg,
    input  logic [DATA_W-1:0] a_data,
    input  logic              b_valid,
    output logic              b_ready,
    input  logic [ADDR_W-1:0] b_reg,
    input  logic [DATA_W-1:0] b_data,
    output logic [ADDR_W-1:0] write_reg,
    output logic [DATA_W-1:0] write_data,
    output logic              write_enable,
    output logic [CNT_W-1:0]  wr_count
);

    localparam logic GRANT_A = 1'b0;
    localparam logic GRANT_B = 1'b1;

    logic              last_grant_reg, last_grant_next;
    logic [ADDR_W-1:0] write_idx_reg, write_idx_next;
    logic [DATA_W-1:0] write_data_reg, write_data_next;
    logic              write_enable_reg, write_enable_next;
    logic [CNT_W-1:0]  wr_count_reg, wr_count_next;

    logic              pref_a;
    logic              accept;
    logic [ADDR_W-1:0] grant_idx;
    logic [DATA_W-1:0] grant_data;

    // A is preferred only when B took the last grant; readies are gated by reset.
    assign pref_a  = (last_grant_reg == GRANT_B);
    assign a_ready = rst_n && !hold && a_valid && (!b_valid || pref_a);
    assign b_ready = rst_n && !hold && b_valid && (!a_valid || !pref_a);
    assign accept  = a_ready || b_ready;

    assign grant_idx  = a_ready ? a_reg  : b_reg;
    assign grant_data = a_ready ? a_data : b_data;

    always_comb begin
        last_grant_next   = last_grant_reg;
        write_idx_next    = write_idx_reg;
        write_data_next   = write_data_reg;
        write_enable_next = 1'b0;
        if (accept) begin
            last_grant_next   = a_ready ? GRANT_A : GRANT_B;
            write_idx_next    = grant_idx;
            write_data_next   = grant_data;
            // Writes to register 0 are consumed but never strobed.
            write_enable_next = (grant_idx != '0);
        end
    end

    always_comb begin
        wr_count_next = wr_count_reg;
        if (write_enable_next && (wr_count_reg != '1)) begin
            wr_count_next = wr_count_reg + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_reg   <= GRANT_B;
            write_idx_reg    <= '0;
            write_data_reg   <= '0;
            write_enable_reg <= 1'b0;
            wr_count_reg     <= '0;
        end else begin
            last_grant_reg   <= last_grant_next;
            write_idx_reg    <= write_idx_next;
            write_data_reg   <= write_data_next;
            write_enable_reg <= write_enable_next;
            wr_count_reg     <= wr_count_next;
        end
    end

    assign write_reg    = write_idx_reg;
    assign write_data   = write_data_reg;
    assign write_enable = write_enable_reg;
    assign wr_count     = wr_count_reg;

endmodule
